// File: rtl/eaglesong_bit_matrix_seq.sv
// eaglesong_bit_matrix_seq: walks the 256 Eaglesong bit-matrix coefficients (one per clock)
// and XOR-accumulates the 16x32-bit state. Optional `EAGLESONG_BM_ABORT_EN adds an abort input.
module eaglesong_bit_matrix_seq #(
    parameter int WORD_W  = 32,
    parameter int N_WORDS = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [WORD_W*N_WORDS-1:0] state_in,
    output logic                      busy,
    output logic                      done,
    output logic [WORD_W*N_WORDS-1:0] state_out,
    output logic [7:0]                bit_index_to_request,
    input  logic                      requested_bit
`ifdef EAGLESONG_BM_ABORT_EN
    ,
    input  logic                      abort
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                           state_q, state_d;
    logic [7:0]                       cnt;
    logic [N_WORDS-1:0][WORD_W-1:0]   in_q, out_q;
    logic [3:0]                       j, k;
    logic                             abort_w;

`ifdef EAGLESONG_BM_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign j         = cnt[7:4];
    assign k         = cnt[3:0];
    assign state_out = out_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next state and status outputs; the lookup index comes straight from flops
    always_comb begin
        state_d              = state_q;
        busy                 = 1'b0;
        done                 = 1'b0;
        bit_index_to_request = 8'd0;
        case (state_q)
            IDLE: state_d = start ? RUN : IDLE;
            RUN: begin
                busy                 = 1'b1;
                bit_index_to_request = {k, j};
                state_d              = abort_w ? IDLE : (cnt == 8'hFF) ? DONE : RUN;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // latch input on accept, then accumulate word k into word j when the coefficient is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 8'd0;
            in_q  <= '0;
            out_q <= '0;
        end else if (state_q == IDLE && start) begin
            cnt   <= 8'd0;
            in_q  <= state_in;
            out_q <= '0;
        end else if (state_q == RUN) begin
            if (abort_w) begin
                cnt   <= 8'd0;
                out_q <= '0;
            end else begin
                if (requested_bit) out_q[j] <= out_q[j] ^ in_q[k];
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_eaglesong_bit_matrix_seq.sv
// tb_eaglesong_bit_matrix_seq: directed table-driven bench with a behavioural coefficient lookup.
module tb_eaglesong_bit_matrix_seq;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [511:0] state_in;
    logic         busy;
    logic         done;
    logic [511:0] state_out;
    logic [7:0]   bit_index_to_request;
    logic         requested_bit;
`ifdef EAGLESONG_BM_ABORT_EN
    logic         abort = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // coefficient rows: row k holds M[16k+15:16k]; rows 0 and 1 are 0x8FAF / 0x9F5E
    logic [15:0]  rows [16] = '{16'h8FAF, 16'h9F5E, 16'h3C5A, 16'hA1F3, 16'h5E07, 16'hC8B2,
                                16'h1D6E, 16'h7094, 16'hE3C1, 16'h4B7D, 16'h92A6, 16'h0F38,
                                16'hD5E9, 16'h6A1C, 16'hB74F, 16'h2890};
    logic [255:0] mtx;

    always_comb begin
        mtx = '0;
        for (int r = 0; r < 16; r++) mtx[16*r +: 16] = rows[r];
    end

    assign requested_bit = mtx[bit_index_to_request];

    eaglesong_bit_matrix_seq dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .state_in            (state_in),
        .busy                (busy),
        .done                (done),
        .state_out           (state_out),
        .bit_index_to_request(bit_index_to_request),
        .requested_bit       (requested_bit)
`ifdef EAGLESONG_BM_ABORT_EN
        ,
        .abort               (abort)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [511:0] vin;
        logic [511:0] vexp;
        bit           poke;
        string        name;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] model(input logic [511:0] s);
        logic [511:0] r = '0;
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < 16; j++)
                if (mtx[16*k+j]) r[32*j +: 32] = r[32*j +: 32] ^ s[32*k +: 32];
        return r;
    endfunction

    function automatic logic [511:0] spread(input logic [15:0] mask, input logic [31:0] w);
        logic [511:0] r = '0;
        for (int j = 0; j < 16; j++) if (mask[j]) r[32*j +: 32] = w;
        return r;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int w = 0; w < 16; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    task automatic count_dones(input int ncyc, output int nd);
        nd = 0;
        repeat (ncyc) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
    endtask

    task automatic run_job(input logic [511:0] vin, input logic [511:0] vexp, input bit poke, input string nm);
        int n;
        int nd;
        @(negedge clk);
        state_in = vin;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        state_in = ~vin;
        n        = 1;
        chk({nm, "_busy_rise"}, {511'd0, busy}, 512'd1);
        chk({nm, "_done_early"}, {511'd0, done}, 512'd0);
        while (!done && n < 400) begin
            start = (poke && n >= 50 && n < 53);
            if (n == 2) chk({nm, "_index"}, {504'd0, bit_index_to_request}, 512'd16);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({nm, "_latency"}, 512'(n), 512'd257);
        chk({nm, "_busy_fall"}, {511'd0, busy}, 512'd0);
        chk({nm, "_out"}, state_out, vexp);
        @(posedge clk); #1;
        chk({nm, "_done_pulse"}, {511'd0, done}, 512'd0);
        chk({nm, "_held"}, state_out, vexp);
        chk({nm, "_idle_index"}, {504'd0, bit_index_to_request}, 512'd0);
        if (poke) begin
            count_dones(300, nd);
            chk({nm, "_extra_done"}, 512'(nd), 512'd0);
        end
    endtask

    initial begin
        logic [511:0] r [3];
        logic [511:0] v;
        int n;
        int nd;
        int last;

        vecs[0] = '{512'd0, 512'd0, 1'b0, "zero"};
        vecs[1] = '{{480'd0, 32'hFFFF_FFFF}, spread(16'h8FAF, 32'hFFFF_FFFF), 1'b0, "word0"};
        vecs[2] = '{{448'd0, 32'h1234_5678, 32'd0}, spread(16'h9F5E, 32'h1234_5678), 1'b1, "word1_restart"};
        vecs[3] = '{{448'd0, 32'd2, 32'd1}, spread(16'h8FAF, 32'd1) ^ spread(16'h9F5E, 32'd2), 1'b0, "two_words"};

        rst_n    = 1'b0;
        start    = 1'b0;
        state_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_busy", {511'd0, busy}, 512'd0);
        chk("reset_done", {511'd0, done}, 512'd0);
        chk("reset_out", state_out, 512'd0);
        chk("reset_index", {504'd0, bit_index_to_request}, 512'd0);

        for (int i = 0; i < 4; i++) run_job(vecs[i].vin, vecs[i].vexp, vecs[i].poke, vecs[i].name);

        for (int i = 0; i < 3; i++) r[i] = rnd512();
        @(negedge clk);
        state_in = r[0];
        start    = 1'b1;
        @(posedge clk); #1;
        state_in = r[1];
        last     = 0;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!done && n < 400) begin
                @(posedge clk); #1;
                n++;
            end
            chk("b2b_done", {511'd0, done}, 512'd1);
            chk("b2b_out", state_out, model(r[i]));
            if (i > 0) chk("b2b_spacing", 512'(cyc - last), 512'd258);
            last = cyc;
            if (i == 2) start = 1'b0;
            @(posedge clk);
            @(posedge clk); #1;
            state_in = (i == 0) ? r[2] : 512'd0;
        end

        v = rnd512();
        @(negedge clk);
        state_in = v;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {511'd0, busy}, 512'd0);
        chk("midrst_done", {511'd0, done}, 512'd0);
        chk("midrst_out", state_out, 512'd0);
        chk("midrst_index", {504'd0, bit_index_to_request}, 512'd0);
        @(negedge clk) rst_n = 1'b1;
        count_dones(300, nd);
        chk("midrst_no_done", 512'(nd), 512'd0);

`ifdef EAGLESONG_BM_ABORT_EN
        @(negedge clk);
        state_in = v;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", {511'd0, busy}, 512'd0);
        chk("abort_out", state_out, 512'd0);
        count_dones(300, nd);
        chk("abort_no_done", 512'(nd), 512'd0);
`endif

        run_job(vecs[1].vin, vecs[1].vexp, 1'b0, "recover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
